// File: rtl/song_reader.sv
// -----------------------------------------------------------------------------
// song_reader
//   Initiator side of the note-load handshake. Walks one song of a synchronous
//   song ROM slot by slot, hands each note to the note player with a one-cycle
//   load strobe, and waits for the player's note_done before fetching the next
//   slot. A duration code of 0, or running off the last slot, ends the song.
//
// Ports
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   play             in   level: 1 = run, 0 = pause/stop
//   song             in   requested song number (sampled only in IDLE)
//   note_done        in   pulse from the note player: current note expired
//   rom_addr         out  {song_reg, note_idx}
//   rom_data         in   {note[11:6], duration[5:0]}, one cycle after rom_addr
//   note_to_load     out  note code for the note player
//   duration_to_load out  duration in beats for the note player
//   new_note         out  one-cycle load strobe (note player load_new_note)
//   play_enable      out  high in every state except IDLE
//   song_done        out  one-cycle pulse at end of song
// -----------------------------------------------------------------------------
module song_reader #(
    parameter int SONG_BITS = 2,
    parameter int NOTE_BITS = 5
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           play,
    input  logic [SONG_BITS-1:0]           song,
    input  logic                           note_done,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [11:0]                    rom_data,
    output logic [5:0]                     note_to_load,
    output logic [5:0]                     duration_to_load,
    output logic                           new_note,
    output logic                           play_enable,
    output logic                           song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RDATA,
        LOAD,
        WAIT_DONE,
        ADVANCE,
        END
    } state_t;

    localparam logic [NOTE_BITS-1:0] LAST_IDX = '1;

    state_t               state;
    state_t               next_state;
    logic [SONG_BITS-1:0] song_reg;
    logic [NOTE_BITS-1:0] note_idx;

    // Datapath controls decoded by the FSM.
    logic load_song;
    logic clear_idx;
    logic inc_idx;
    logic capture;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        load_song  = 1'b0;
        clear_idx  = 1'b0;
        inc_idx    = 1'b0;
        capture    = 1'b0;

        // Pause wins over everything else, including a note_done arriving in
        // the same cycle; the index is kept so the interrupted note replays.
        if (!play && state != IDLE && state != END) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // A song change costs one IDLE cycle and restarts at slot 0.
                    if (song != song_reg) begin
                        load_song = 1'b1;
                        clear_idx = 1'b1;
                    end else if (play) begin
                        next_state = FETCH;
                    end
                end
                FETCH: begin
                    // rom_addr is stable; the ROM registers it on this edge.
                    next_state = RDATA;
                end
                RDATA: begin
                    // The end marker is still captured so the outputs show it.
                    capture    = 1'b1;
                    next_state = (rom_data[5:0] == '0) ? END : LOAD;
                end
                LOAD: begin
                    next_state = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (note_done) begin
                        next_state = ADVANCE;
                    end
                end
                ADVANCE: begin
                    // Index never wraps by overflow; only END clears it.
                    if (note_idx == LAST_IDX) begin
                        next_state = END;
                    end else begin
                        inc_idx    = 1'b1;
                        next_state = FETCH;
                    end
                end
                END: begin
                    clear_idx  = 1'b1;
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            song_reg         <= '0;
            note_idx         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
        end else begin
            if (load_song) begin
                song_reg <= song;
            end
            if (clear_idx) begin
                note_idx <= '0;
            end else if (inc_idx) begin
                note_idx <= note_idx + 1'b1;
            end
            if (capture) begin
                note_to_load     <= rom_data[11:6];
                duration_to_load <= rom_data[5:0];
            end
        end
    end

    // Status outputs decode straight from state, so asserting reset_n clears
    // them immediately rather than at the next edge.
    assign rom_addr    = {song_reg, note_idx};
    assign new_note    = (state == LOAD);
    assign play_enable = (state != IDLE);
    assign song_done   = (state == END);

endmodule

// File: tb/tb_song_reader.sv
// -----------------------------------------------------------------------------
// tb_song_reader
//   Self-checking bench for song_reader. A synchronous ROM model holds four
//   songs (song 0 fixed, the rest random). A transaction-level reference
//   tracks the current song and slot, predicts which ROM word each load
//   strobe must carry and when the strobe or song_done must appear, and
//   injects random note_done timing, ignored note_done pulses, song-select
//   wiggles outside IDLE, pauses and an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_song_reader;

    localparam int SLOTS = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic [1:0]  song = 2'd0;
    logic        note_done = 1'b0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        new_note;
    logic        play_enable;
    logic        song_done;

    logic [11:0] rom [0:127];

    int total = 0;
    int bad   = 0;

    // Reference model: which song/slot the reader should be on.
    int m_song = 0;
    int m_idx  = 0;
    bit ended;
    bit stopped;
    int notes_seen;

    song_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .play             (play),
        .song             (song),
        .note_done        (note_done),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .new_note         (new_note),
        .play_enable      (play_enable),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data follows the address by one clock.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] addr_of(input int s, input int i);
        return 7'(s * SLOTS + i);
    endfunction

    // Advance n clocks; only the last one may show the expected event.
    // Optional stray note_done pulses land in states that must ignore them.
    task automatic expect_event(input int n, input bit want_done, input bit spur);
        for (int i = 1; i <= n; i++) begin
            note_done = spur && ($urandom_range(0, 1) == 1);
            tick();
            if (i < n)
                check("quiet_gap", {new_note, song_done}, 2'b00);
            else
                check(want_done ? "song_done_latency" : "new_note_latency",
                      {new_note, song_done}, want_done ? 2'b01 : 2'b10);
        end
        note_done = 1'b0;
    endtask

    // Called on the song_done cycle; w is the last word the reader captured.
    task automatic finish_song(input logic [11:0] w);
        check("end_note", note_to_load, w[11:6]);
        check("end_dur", duration_to_load, w[5:0]);
        check("end_enable", play_enable, 1);
        tick();
        check("after_end", {play_enable, song_done, new_note}, 3'b000);
        check("end_index_cleared", rom_addr, addr_of(m_song, 0));
        play   = 1'b0;
        m_idx  = 0;
        ended  = 1'b1;
    endtask

    // Only legal in IDLE with play low and a song different from the current.
    task automatic change_song(input int s);
        song = 2'(s);
        tick();
        check("song_change_addr", rom_addr, addr_of(s, 0));
        m_song = s;
        m_idx  = 0;
    endtask

    // Play from IDLE. fixed_d > 0 fixes the note_done delay; pause_idx /
    // reset_idx interrupt the note at that slot (-1 = never).
    task automatic run_notes(input int fixed_d, input bit spur,
                             input int pause_idx, input int reset_idx);
        logic [11:0] w;
        int          d;
        bit          wander;
        ended      = 1'b0;
        stopped    = 1'b0;
        notes_seen = 0;
        play       = 1'b1;
        w = rom[addr_of(m_song, m_idx)];
        expect_event(3, w[5:0] == 6'd0, spur);
        forever begin
            if (w[5:0] == 6'd0) begin
                finish_song(w);
                return;
            end
            notes_seen++;
            check("load_note", note_to_load, w[11:6]);
            check("load_dur", duration_to_load, w[5:0]);
            check("load_addr", rom_addr, addr_of(m_song, m_idx));

            // Stray note_done during the load cycle must be ignored.
            note_done = spur && ($urandom_range(0, 1) == 1);
            d      = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 5));
            wander = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < d; i++) begin
                tick();
                note_done = 1'b0;
                if (wander) song = 2'($urandom_range(0, 3));
                check("wait_hold", {new_note, song_done, play_enable}, 3'b001);
            end
            song = 2'(m_song);

            if (reset_idx == m_idx) begin
                #3 reset_n = 1'b0;
                #1;
                check("async_reset_outputs",
                      {new_note, play_enable, song_done, rom_addr, note_to_load, duration_to_load},
                      32'd0);
                play   = 1'b0;
                song   = 2'd0;
                m_song = 0;
                m_idx  = 0;
                tick();
                tick();
                #2 reset_n = 1'b1;
                stopped = 1'b1;
                return;
            end

            if (pause_idx == m_idx) begin
                play      = 1'b0;
                note_done = 1'b1;
                tick();
                note_done = 1'b0;
                check("pause_idle", play_enable, 0);
                check("pause_index_kept", rom_addr, addr_of(m_song, m_idx));
                stopped = 1'b1;
                return;
            end

            note_done = 1'b1;
            tick();
            note_done = 1'b0;
            check("advance_quiet", {new_note, song_done}, 2'b00);
            if (m_idx == SLOTS - 1) begin
                expect_event(1, 1'b1, spur);
                finish_song(w);
                return;
            end
            m_idx++;
            w = rom[addr_of(m_song, m_idx)];
            expect_event(3, w[5:0] == 6'd0, spur);
        end
    endtask

    initial begin
        int p;

        for (int i = 0; i < 128; i++)
            rom[i] = {6'($urandom), 6'($urandom_range(1, 63))};
        // Song 0: two notes then an end marker.
        rom[0] = {6'd10, 6'd4};
        rom[1] = {6'd12, 6'd2};
        rom[2] = 12'd0;
        // Songs 2 and 3 may end early; their first few slots always play.
        for (int i = 70; i < 96; i++)
            if ($urandom_range(0, 7) == 0) rom[i][5:0] = 6'd0;
        for (int i = 100; i < 128; i++)
            if ($urandom_range(0, 7) == 0) rom[i][5:0] = 6'd0;

        // Reset state.
        #12;
        check("reset_addr", rom_addr, 0);
        check("reset_note", note_to_load, 0);
        check("reset_dur", duration_to_load, 0);
        check("reset_flags", {new_note, play_enable, song_done}, 3'b000);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("idle_after_reset", play_enable, 0);

        // Song 0 with play held and note_done five cycles after each load.
        run_notes(5, 1'b0, -1, -1);
        check("song0_ended", ended, 1);
        check("song0_notes", notes_seen, 2);

        // Song 1: every slot plays, then wraps back to slot 0.
        change_song(1);
        run_notes(0, 1'b1, -1, -1);
        check("song1_ended", ended, 1);
        check("song1_notes", notes_seen, SLOTS);

        // Pause song 1 at slot 5, then switch to song 2 from IDLE.
        run_notes(0, 1'b1, 5, -1);
        check("song1_paused", stopped, 1);
        change_song(2);

        // Pause song 2 at slot 3 together with note_done, then resume.
        run_notes(0, 1'b1, 3, -1);
        check("song2_paused", stopped, 1);
        run_notes(0, 1'b1, -1, -1);
        check("song2_ended", ended, 1);

        // Song 3 with a pause at a random slot (may lie past the end marker).
        change_song(3);
        p = int'($urandom_range(0, SLOTS - 1));
        run_notes(0, 1'b1, p, -1);
        if (!ended) run_notes(0, 1'b1, -1, -1);
        check("song3_ended", ended, 1);

        // Asynchronous reset in the middle of slot 2, then restart on song 0.
        run_notes(0, 1'b0, -1, 2);
        check("reset_interrupted", stopped, 1);
        run_notes(0, 1'b1, -1, -1);
        check("restart_ended", ended, 1);
        check("restart_notes", notes_seen, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
